pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 13 +
 rtl/ras_stack.sv | 58 +++++
 rtl/pc_sequencer.sv | 110 +++++++++++
 tb/tb_pc_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the PC sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
  localparam logic [63:0] DEFAULT_TRAP_PC  = 64'h100;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr;
  logic [CntW-1:0] count_q, count_d;

  assign rd_ptr = wr_ptr_q - PtrW'(1);
  assign top    = mem_q[rd_ptr];
  assign empty  = (count_q == '0);
  assign full   = (count_q == CntW'(RAS_DEPTH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      count_d = '0;
    end else if (push) begin
      // Pointer wraps onto the oldest slot once full; count saturates.
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (!full) count_d = count_q + CntW'(1);
    end else if (pop && !empty) begin
      wr_ptr_d = rd_ptr;
      count_d  = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot/run/halt control, redirects, traps and call/return prediction.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 64,
  parameter int unsigned     STEP      = 1,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
  parameter logic [XLEN-1:0] TRAP_PC   = XLEN'(DEFAULT_TRAP_PC),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_overflow
);

  localparam logic [XLEN-1:0] StepInc = XLEN'(STEP);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic            ras_push, ras_pop, ras_clear, ras_full;
  logic [XLEN-1:0] ras_top;

  assign pc           = pc_q;
  assign pc_next      = pc_q + StepInc;
  assign pc_valid     = (state_q == RUN);
  assign ras_overflow = ovf_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap) begin
          pc_d      = TRAP_PC;
          ras_clear = 1'b1;
        end else if (redirect_valid) begin
          if (call) begin
            pc_d     = redirect_pc;
            ras_push = 1'b1;
          end else if (ret && !ras_empty) begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (halt) begin
          state_d = HALT;
        end else if (!stall) begin
          pc_d = pc_next;
        end
      end
      HALT: begin
        if (trap) begin
          pc_d      = TRAP_PC;
          ras_clear = 1'b1;
          state_d   = RUN;
        end else if (resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    ovf_d = ovf_q | (ras_push & ras_full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (pc_next),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic vs a queue model.
module tb_pc_sequencer;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] TRAP  = 64'h100;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            stall, redirect_valid, call, ret, trap, halt, resume;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc, pc_next;
  logic            pc_valid, ras_empty, ras_overflow;

  always #5 clk = ~clk;

  pc_sequencer #(
    .XLEN      (XLEN),
    .STEP      (1),
    .RESET_PC  (64'h0),
    .TRAP_PC   (TRAP),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .call           (call),
    .ret            (ret),
    .trap           (trap),
    .halt           (halt),
    .resume         (resume),
    .pc             (pc),
    .pc_next        (pc_next),
    .pc_valid       (pc_valid),
    .ras_empty      (ras_empty),
    .ras_overflow   (ras_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 = boot, 1 = run, 2 = halt; RAS as a queue (back = newest).
  logic [63:0] m_pc;
  int          m_mode;
  logic [63:0] m_ras[$];
  logic        m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string step);
    check({step, " pc"}, pc, m_pc);
    check({step, " pc_next"}, pc_next, m_pc + 64'd1);
    check({step, " pc_valid"}, {63'b0, pc_valid}, {63'b0, m_mode == 1});
    check({step, " ras_empty"}, {63'b0, ras_empty}, {63'b0, m_ras.size() == 0});
    check({step, " ras_overflow"}, {63'b0, ras_overflow}, {63'b0, m_ovf});
  endtask

  task automatic model_reset();
    m_pc   = 64'h0;
    m_mode = 0;
    m_ras.delete();
    m_ovf  = 1'b0;
  endtask

  task automatic model_step();
    logic [63:0] link;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (trap) begin
      m_pc   = TRAP;
      m_ras.delete();
      m_mode = 1;
    end else if (m_mode == 2) begin
      if (resume) m_mode = 1;
    end else if (redirect_valid) begin
      if (call) begin
        link = m_pc + 64'd1;
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(link);
        m_pc = redirect_pc;
      end else if (ret && m_ras.size() != 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        m_pc = redirect_pc;
      end
    end else if (halt) begin
      m_mode = 2;
    end else if (!stall) begin
      m_pc = m_pc + 64'd1;
    end
  endtask

  task automatic clear_inputs();
    stall = 0; redirect_valid = 0; call = 0; ret = 0;
    trap = 0; halt = 0; resume = 0; redirect_pc = '0;
  endtask

  task automatic tick(input string step);
    model_step();
    @(posedge clk);
    #1;
    check_all(step);
  endtask

  task automatic do_redirect(input logic c, input logic r, input logic [63:0] tgt, input string step);
    redirect_valid = 1; call = c; ret = r; redirect_pc = tgt;
    tick(step);
    redirect_valid = 0; call = 0; ret = 0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #2 rst = 1;
    #10 check_all("reset");
    @(posedge clk);
    #1 check_all("reset held");
    rst = 0;
    check_all("boot");
    for (int i = 0; i < 4; i++) tick("idle after boot");
    check("pc after 4 idle", pc, 64'd3);

    // Call from pc=5 and matching return.
    tick("idle");
    tick("idle");
    do_redirect(1, 0, 64'd40, "call 40");
    check("call target", pc, 64'd40);
    tick("idle in callee");
    do_redirect(0, 1, 64'd99, "ret");
    check("ret link", pc, 64'd6);

    // Overflow: five calls into a four-deep stack, then five returns.
    for (int i = 1; i <= 5; i++) do_redirect(1, 0, 64'(i * 100), "call chain");
    check("overflow flag", {63'b0, ras_overflow}, 64'd1);
    for (int i = 4; i >= 1; i--) begin
      do_redirect(0, 1, 64'd77, "ret chain");
      check("ret chain link", pc, 64'(i * 100 + 1));
    end
    do_redirect(0, 1, 64'd77, "ret on empty");
    check("ret on empty", pc, 64'd77);

    // Redirect wins over stall; stall alone holds.
    stall = 1;
    do_redirect(0, 0, 64'd20, "stall+redirect");
    check("stall+redirect", pc, 64'd20);
    for (int i = 0; i < 3; i++) tick("stall hold");
    check("stall hold", pc, 64'd20);
    stall = 0;

    // Halt, ignored inputs in HALT, trap out of HALT.
    do_redirect(0, 0, 64'd6, "redirect 6");
    tick("idle");
    halt = 1;
    tick("enter halt");
    halt = 0;
    check("halt pc", pc, 64'd7);
    stall = 1;
    do_redirect(1, 1, 64'd55, "ignored in halt");
    stall = 0;
    trap = 1;
    tick("trap from halt");
    trap = 0;
    check("trap pc", pc, TRAP);
    halt = 1;
    tick("halt again");
    halt = 0;
    tick("halted idle");
    resume = 1;
    tick("resume");
    resume = 0;
    tick("after resume");

    // Wrap of all-ones.
    do_redirect(0, 0, ONES, "to all-ones");
    tick("wrap");
    check("wrap to zero", pc, 64'd0);

    // Asynchronous reset in the middle of a call cycle.
    do_redirect(1, 0, 64'd300, "pre-reset call");
    redirect_valid = 1; call = 1; redirect_pc = 64'd500;
    #2 rst = 1;
    #1 model_reset();
    check_all("async reset");
    @(posedge clk);
    #1 check_all("reset over call");
    rst = 0;
    clear_inputs();
    check_all("boot 2");
    trap = 1;
    tick("trap in boot");
    trap = 0;
    check("trap in boot", pc, 64'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      trap           = ($urandom_range(0, 99) < 3);
      redirect_valid = ($urandom_range(0, 3) == 0);
      call           = ($urandom_range(0, 2) == 0);
      ret            = ($urandom_range(0, 2) == 0);
      halt           = ($urandom_range(0, 19) == 0);
      resume         = ($urandom_range(0, 3) == 0);
      stall          = ($urandom_range(0, 4) == 0);
      redirect_pc    = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) redirect_pc = ONES - 64'($urandom_range(0, 2));
      tick("random");
    end
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
